// File: rtl/dcache_2way.sv
// dcache_2way: two-way set-associative, write-back, write-allocate data cache.
// Per-set LRU bit, victim way registered at the miss edge.
// Optional hit/miss statistics counters enabled by defining DCACHE_STATS_EN.
module dcache_2way #(
    parameter int ADDR_W   = 8,
    parameter int INDEX_W  = 3,
    parameter int OFFSET_W = 2,
    localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W,
    localparam int BLK_W   = 8 << OFFSET_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ADDR_W-1:0]          CPUaddress,
    input  logic                       CPUread,
    input  logic                       CPUwrite,
    input  logic [7:0]                 CPUwritedata,
    output logic [7:0]                 CPUreaddata,
    output logic                       CPUbusywait,
    output logic [ADDR_W-OFFSET_W-1:0] mem_address,
    output logic                       mem_read,
    output logic                       mem_write,
    output logic [BLK_W-1:0]           mem_writedata,
    input  logic [BLK_W-1:0]           mem_readdata,
    input  logic                       mem_busywait
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]                hit_count,
    output logic [15:0]                miss_count
`endif
);

    localparam int SETS = 1 << INDEX_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH} state_t;

    state_t                state_q, state_d;
    logic [1:0][SETS-1:0]  valid_q, dirty_q;
    logic [SETS-1:0]       lru_q;
    logic [TAG_W-1:0]      tag_q  [2][SETS];
    logic [BLK_W-1:0]      data_q [2][SETS];
    logic                  victim_q, victim_d;

    logic [TAG_W-1:0]      addr_tag;
    logic [INDEX_W-1:0]    addr_index;
    logic [OFFSET_W-1:0]   addr_offset;
    logic                  hit0, hit1, hit, hit_way, req, idle_hit, miss_start, mem_done;

    assign addr_tag    = CPUaddress[ADDR_W-1 -: TAG_W];
    assign addr_index  = CPUaddress[OFFSET_W +: INDEX_W];
    assign addr_offset = CPUaddress[OFFSET_W-1:0];

    assign hit0       = valid_q[0][addr_index] && (tag_q[0][addr_index] == addr_tag);
    assign hit1       = valid_q[1][addr_index] && (tag_q[1][addr_index] == addr_tag);
    assign hit        = hit0 | hit1;
    assign hit_way    = hit1;
    assign req        = CPUread | CPUwrite;
    assign idle_hit   = req && hit && (state_q == IDLE);
    assign miss_start = req && !hit && (state_q == IDLE);
    assign mem_done   = !mem_busywait;

    assign CPUbusywait = req && !((state_q == IDLE) && hit);
    assign CPUreaddata = data_q[hit_way][addr_index][{addr_offset, 3'b000} +: 8];

    // Victim selection: invalid way first (way 0 before way 1), else the LRU way
    always_comb begin
        victim_d = lru_q[addr_index];
        if (!valid_q[0][addr_index])
            victim_d = 1'b0;
        else if (!valid_q[1][addr_index])
            victim_d = 1'b1;
    end

    // Next-state and memory-side strobes
    always_comb begin
        state_d       = state_q;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        case (state_q)
            IDLE: begin
                if (req && !hit)
                    state_d = (valid_q[victim_d][addr_index] && dirty_q[victim_d][addr_index])
                              ? WRITEBACK : FETCH;
            end
            WRITEBACK: begin
                mem_write     = 1'b1;
                mem_address   = {tag_q[victim_q][addr_index], addr_index};
                mem_writedata = data_q[victim_q][addr_index];
                if (mem_done)
                    state_d = FETCH;
            end
            FETCH: begin
                mem_read    = 1'b1;
                mem_address = {addr_tag, addr_index};
                if (mem_done)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register and victim capture at the miss edge
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            victim_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (miss_start)
                victim_q <= victim_d;
        end
    end

    // Valid, dirty and LRU bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
            lru_q   <= '0;
        end else if (idle_hit) begin
            lru_q[addr_index] <= ~hit_way;
            if (CPUwrite)
                dirty_q[hit_way][addr_index] <= 1'b1;
        end else if ((state_q == WRITEBACK) && mem_done) begin
            dirty_q[victim_q][addr_index] <= 1'b0;
        end else if ((state_q == FETCH) && mem_done) begin
            valid_q[victim_q][addr_index] <= 1'b1;
            dirty_q[victim_q][addr_index] <= 1'b0;
            lru_q[addr_index]             <= ~victim_q;
        end
    end

    // Tag and data storage: store byte on write hit, whole block on refill
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (idle_hit && CPUwrite) begin
                data_q[hit_way][addr_index][{addr_offset, 3'b000} +: 8] <= CPUwritedata;
            end else if ((state_q == FETCH) && mem_done) begin
                data_q[victim_q][addr_index] <= mem_readdata;
                tag_q[victim_q][addr_index]  <= addr_tag;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    logic refilled_q;

    // Saturating counters; the hit that finishes a refilled request is not a hit
    always_ff @(posedge clk) begin
        if (reset) begin
            refilled_q <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            refilled_q <= (state_q == FETCH) && mem_done;
            if (idle_hit && !refilled_q && (hit_count != 16'hFFFF))
                hit_count <= hit_count + 16'd1;
            if (miss_start && (miss_count != 16'hFFFF))
                miss_count <= miss_count + 16'd1;
        end
    end
`endif

endmodule

// File: doc/dcache_2way.md
# dcache_2way

Parametrised two-way set-associative, write-back, write-allocate data cache. It sits between the CPU load/store path and the block-wide data memory, and replaces the direct-mapped data cache. Set count and block size are generalised through parameters. It adds per-set LRU replacement, a registered victim way and optional hit/miss statistics.

## Interface
- ADDR_W, default 8: CPU byte-address width.
- INDEX_W, default 3: set-index bits; sets = 2^INDEX_W.
- OFFSET_W, default 2: byte-offset bits; block = 2^OFFSET_W bytes, BLK_W = 8<<OFFSET_W bits.
- TAG_W (derived): ADDR_W-INDEX_W-OFFSET_W.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- CPUaddress  in  ADDR_W  byte address, split as {tag, index, offset}.
- CPUread  in  1  load request, held until CPUbusywait is low.
- CPUwrite  in  1  store request, held until CPUbusywait is low.
- CPUwritedata  in  8  store byte.
- CPUreaddata  out  8  load byte.
- CPUbusywait  out  1  stall to the CPU.
- mem_address  out  ADDR_W-OFFSET_W  block address.
- mem_read  out  1  block read request.
- mem_write  out  1  block write request.
- mem_writedata  out  BLK_W  writeback block.
- mem_readdata  in  BLK_W  fetched block.
- mem_busywait  in  1  memory stall; memory asserts it combinationally in the cycle it first sees mem_read or mem_write.

## Operation
- Storage per set: two ways, each holding valid, dirty, tag and a BLK_W data field. Each set also holds one lru bit, which names the least-recently-used way.
- Byte k of a block occupies bits [8k+7:8k].
- Hit: the request is active in IDLE and a valid way's tag equals the address tag. Way 0 and way 1 can never both match.
- If CPUread and CPUwrite are both high, the request is treated as a write.
- FSM states: IDLE, WRITEBACK, FETCH.
- IDLE with a hit:
  - Read: CPUreaddata is driven combinationally from the hit way.
  - Write: the byte is written at the edge and the way's dirty bit is set.
  - Either case: lru is set to the other way at the edge.
- IDLE with a miss: the victim is chosen at the edge and registered. An invalid way is chosen first, way 0 before way 1; otherwise the LRU way is the victim.
  - Victim valid and dirty: go to WRITEBACK.
  - Otherwise: go to FETCH.
- WRITEBACK: drive mem_write=1, mem_address={victim tag, index}, mem_writedata=victim data. At the edge where mem_busywait=0, clear the victim's dirty bit and go to FETCH.
- FETCH: drive mem_read=1, mem_address={tag, index}. At the edge where mem_busywait=0:
  - load mem_readdata into the victim;
  - set valid=1, dirty=0, tag=address tag;
  - set lru to the non-victim way;
  - go to IDLE.
- The request then completes as a hit in IDLE.
- In IDLE, mem_read=0 and mem_write=0; mem_address and mem_writedata are don't-care.

## Timing
- CPUbusywait is combinational: (CPUread|CPUwrite) & !(state==IDLE & hit).
- Read-hit latency: 0 cycles of stall; data is valid in the request cycle.
- Write hit: no stall; the store commits at the next edge.
- Clean miss: stall = 1 (IDLE detect) + F cycles in FETCH + 0. F is the number of FETCH cycles up to and including the one that samples mem_busywait=0.
- Dirty miss: stall = 1 + W + F, where W is the number of WRITEBACK cycles.
- mem_address, mem_writedata and the request strobes stay constant throughout each memory state.
- The victim is registered, so LRU or CPU activity cannot change it mid-miss.
- Reset values:
  - state IDLE;
  - every valid, dirty and lru bit 0;
  - mem_read=0, mem_write=0;
  - CPUbusywait=0 when no request is present.
- Reset asserted mid-miss: the memory transaction is abandoned and the strobes drop after that edge. Dirty data in the cache is lost.

## Configuration
- DCACHE_STATS_EN defined: adds output ports hit_count[15:0] and miss_count[15:0], both reset to 0.
  - hit_count increments at each edge that completes an IDLE hit. A request that completes after a refill does not count as a hit.
  - miss_count increments at each IDLE-to-miss edge.
  - Both counters saturate at 16'hFFFF.
- DCACHE_STATS_EN undefined: the counters and their ports are absent, and the cache behaves the same in every other respect.

## Test plan
All scenarios use the default parameters; memory returns block N for address N with 2 busy cycles.
- Reset, then read 0x05 → mem_read=1 with mem_address=0x01; block 0x44332211 loads into set 1, way 0; CPUreaddata=0x22; stall 4 cycles.
- Read 0x24 (set 1 miss, fills way 1), then write 0x5A to 0x05 → no stall, way 0 becomes dirty, lru=1.
- Read 0x44 → way 1 (tag 1, clean) is evicted with no mem_write; then read 0x64 → WRITEBACK with mem_address=0x01 and byte 1 of mem_writedata = 0x5A, followed by FETCH of 0x19.
- Assert reset during FETCH → the next cycle shows mem_read=0 and state IDLE; the next read of 0x05 misses.
- Assert CPUread and CPUwrite together on a hit → the byte is written and the dirty bit is set.
- With DCACHE_STATS_EN, run the first three scenarios → miss_count=4, hit_count=1.
